// File: rtl/bram.sv
// Single-port block RAM, write-first, with synchronous output register.
// Define BRAM_OUT_REG_EN to add a second output register (read latency 2).
module bram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  ena,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Declaration initialiser gives all-zero contents at time zero in simulation.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] douta_d;
   logic [DATA_WIDTH-1:0] douta_q;

   // Writes ignore reset; only the output register is cleared.
   assign wr_en = ena & wea;

   always_comb begin
      douta_d = douta_q;
      if (ena) begin
         if (wea) begin
            douta_d = dina;
         end else begin
            douta_d = mem_q[addra];
         end
      end
   end

   always_ff @(posedge clka) begin
      if (wr_en) begin
         mem_q[addra] <= dina;
      end
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         douta_q <= '0;
      end else begin
         douta_q <= douta_d;
      end
   end

`ifdef BRAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] dout_pipe_d;
   logic [DATA_WIDTH-1:0] dout_pipe_q;

   // Free-running stage: advances every cycle regardless of ena.
   always_comb begin
      dout_pipe_d = douta_q;
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         dout_pipe_q <= '0;
      end else begin
         dout_pipe_q <= dout_pipe_d;
      end
   end

   assign douta = dout_pipe_q;
`else
   assign douta = douta_q;
`endif

endmodule

// File: tb/tb_bram.sv
// Directed self-checking bench for bram (both build variants).
module tb_bram;

   localparam int DW = 32;
   localparam int AW = 7;

   logic          clka = 1'b0;
   logic          rsta;
   logic          ena;
   logic          wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic [DW-1:0] douta;

   int n_checks = 0;
   int n_errors = 0;

   bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clka  (clka),
      .rsta  (rsta),
      .ena   (ena),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta)
   );

   always #5 clka = ~clka;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One edge, then settle; the extra register variant needs one more edge.
   task automatic tick();
      @(posedge clka);
      #1;
`ifdef BRAM_OUT_REG_EN
      @(posedge clka);
      #1;
`endif
   endtask

   task automatic drive(input logic r, input logic e, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      rsta  = r;
      ena   = e;
      wea   = w;
      addra = a;
      dina  = d;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      chk("reset_clear", douta, 32'h0);

      drive(1'b0, 1'b1, 1'b1, 7'h00, 32'h12345678);
      tick();
      chk("wfirst_a0", douta, 32'h12345678);
      drive(1'b0, 1'b1, 1'b1, 7'h01, 32'h98765432);
      tick();
      chk("wfirst_a1", douta, 32'h98765432);

      drive(1'b0, 1'b1, 1'b1, 7'h01, 32'h89abcdef);
      chk("ovw_before", douta, 32'h98765432);
      tick();
      chk("ovw_after", douta, 32'h89abcdef);

      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      tick();
      chk("read_a0", douta, 32'h12345678);
      drive(1'b0, 1'b1, 1'b0, 7'h01, '0);
      tick();
      chk("read_a1_ovw", douta, 32'h89abcdef);

      drive(1'b0, 1'b0, 1'b1, 7'h00, 32'hDEADBEEF);
      tick();
      chk("ena0_hold", douta, 32'h89abcdef);
      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      tick();
      chk("ena0_no_write", douta, 32'h12345678);
      drive(1'b0, 1'b0, 1'b0, 7'h01, '0);
      tick();
      chk("ena0_addr_chg_hold", douta, 32'h12345678);

      drive(1'b1, 1'b1, 1'b1, 7'h02, 32'hCAFEF00D);
      tick();
      chk("rst_write_clear", douta, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 7'h02, '0);
      tick();
      chk("rst_write_kept", douta, 32'hCAFEF00D);

      drive(1'b1, 1'b0, 1'b0, 7'h00, '0);
      tick();
      chk("rst_ena0_clear", douta, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      tick();
      chk("rst_mem_kept", douta, 32'h12345678);

      drive(1'b0, 1'b1, 1'b0, 7'h7F, '0);
      tick();
      chk("init_zero_top", douta, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 7'h7F, 32'hA5A5A5A5);
      tick();
      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      tick();
      chk("top_no_alias", douta, 32'h12345678);
      drive(1'b0, 1'b1, 1'b0, 7'h7F, '0);
      tick();
      chk("top_read", douta, 32'hA5A5A5A5);

      drive(1'b0, 1'b1, 1'b1, 7'h03, 32'h00000001);
      tick();
      drive(1'b0, 1'b1, 1'b1, 7'h03, 32'h00000002);
      tick();
      drive(1'b0, 1'b1, 1'b0, 7'h03, '0);
      tick();
      chk("b2b_last_wins", douta, 32'h00000002);

`ifdef BRAM_OUT_REG_EN
      drive(1'b0, 1'b1, 1'b0, 7'h01, '0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      @(posedge clka);
      #1;
      chk("oreg_lat1_old", douta, 32'h89abcdef);
      @(posedge clka);
      #1;
      chk("oreg_lat2_new", douta, 32'h12345678);
`else
      drive(1'b0, 1'b1, 1'b0, 7'h00, '0);
      @(posedge clka);
      #1;
      chk("lat1_read", douta, 32'h12345678);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bram.md
BRAM -- requirements
Module: bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: address width, giving 2**ADDR_WIDTH words (128).
REQ-003 SHALL have port clka, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rsta, input, 1 bit: reset, synchronous to clka and active-high.
REQ-005 SHALL have port ena, input, 1 bit: port enable; gates both read and write.
REQ-006 SHALL have port wea, input, 1 bit: write enable, qualified by ena.
REQ-007 SHALL have port addra, input, ADDR_WIDTH bits: word address.
REQ-008 SHALL have port dina, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port douta, output, DATA_WIDTH bits: registered read data.

Function
REQ-010 SHALL implement a single-port RAM of 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-011 SHALL write dina to mem[addra] on a rising edge where ena=1 and wea=1 and rsta=0.
REQ-012 SHALL, on a rising edge with ena=1 and wea=0 and rsta=0, load douta with mem[addra].
- Read latency: 1 clock.
REQ-013 SHALL be write-first: on a rising edge with ena=1 and wea=1 and rsta=0, douta is loaded with dina (the new data), not the old contents.
REQ-014 SHALL, with ena=0, perform neither read nor write; douta and memory hold their values.
REQ-015 SHALL ignore wea when ena=0.
REQ-016 SHALL use all ADDR_WIDTH address bits directly; no wrap or aliasing logic is needed (full range valid).
REQ-017 SHALL make back-to-back writes to the same address in consecutive cycles each take effect in order; the last one wins.
REQ-018 SHALL make a read of an address in the cycle after it is written return the new data.
REQ-019 SHALL initialise all memory words to 0 at time zero for simulation.

Reset
REQ-020 SHALL clear douta (and any output pipeline register) to 0 on a rising edge with rsta=1, regardless of ena.
REQ-021 SHALL NOT clear memory contents on reset.
REQ-022 SHALL still perform the write when rsta=1 coincides with ena=1 and wea=1; douta is still cleared to 0.
REQ-023 SHALL resume normal reads on the first edge with rsta=0.

Configuration
REQ-024 SHALL support macro BRAM_OUT_REG_EN.
- Defined: an extra output register follows the read/write-first register; read latency becomes 2 clocks.
- The extra register advances every cycle regardless of ena and is cleared by rsta.
REQ-025 SHALL, when BRAM_OUT_REG_EN is undefined, have read latency exactly 1 clock as in REQ-012/013.

Verification (default build unless noted)
REQ-026 SHALL pass the write-first test:
- Stimulus: ena=1, wea=1, addr 0x00 <- 0x12345678, then next cycle addr 0x01 <- 0x98765432.
- Response: douta=0x98765432 one cycle after the second write.
REQ-027 SHALL pass the overwrite test:
- Stimulus: addr 0x01 written 0x89abcdef; douta sampled before that edge.
- Response: douta=0x98765432 before the edge, 0x89abcdef after it.
REQ-028 SHALL pass the read test:
- Stimulus: wea=0, addr 0x00 after the writes above.
- Response: douta=0x12345678 one cycle later.
REQ-029 SHALL pass the enable test:
- Stimulus: ena=0, wea=1, addr 0x00, dina=0xDEADBEEF, then ena=1, wea=0, addr 0x00.
- Response: douta holds during ena=0 and then reads 0x12345678.
REQ-030 SHALL pass the reset test:
- Stimulus: rsta=1 for one edge with ena=1, wea=1, addr 0x02, dina=0xCAFEF00D.
- Response: douta=0 after that edge; a later read of 0x02 returns 0xCAFEF00D.
REQ-031 SHALL pass the output-register test (BRAM_OUT_REG_EN defined):
- Stimulus: a read of 0x00.
- Response: 0x12345678 appears on douta 2 cycles after addra is presented.
